// File: rtl/ysyx_25050147_core_pkg.sv
// Shared types and constants for the multi-cycle fetch/execute sequencer.
package ysyx_25050147_core_pkg;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StWait  = 2'd1,
    StExec  = 2'd2,
    StHalt  = 2'd3
  } seq_state_e;

  localparam logic [4:0] OP_EBREAK = 5'd0;
  localparam logic [4:0] OP_JUMP   = 5'd1;

  localparam logic [1:0] HALT_EBREAK   = 2'd0;
  localparam logic [1:0] HALT_BUS_ERR  = 2'd1;
  localparam logic [1:0] HALT_TIMEOUT  = 2'd2;
  localparam logic [1:0] HALT_MISALIGN = 2'd3;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ysyx_25050147_mc_seq_if.sv
// Instruction-memory request/response channel between sequencer (master) and memory (slave).
interface ysyx_25050147_mc_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            imem_rsp_err;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  imem_rsp_err
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output imem_rsp_err
  );
endinterface

// File: rtl/ysyx_25050147_perf_cnt.sv
// 64-bit event counter that sticks at all-ones instead of wrapping.
module ysyx_25050147_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [63:0] count
);
  logic [63:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != '1)) count_d = count_q + 64'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/ysyx_25050147_mc_seq.sv
// Multi-cycle fetch/wait/exec sequencer owning PC, IR and writeback gating.
// Define YSYX_25050147_PERF_CNT_EN to build the cycle/instret counters.
module ysyx_25050147_mc_seq
  import ysyx_25050147_core_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int unsigned     TIMEOUT  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ysyx_25050147_mc_seq_if.master imem,
  output logic [31:0]            inst,
  input  logic [4:0]             op_type,
  input  logic [4:0]             rd,
  input  logic [XLEN-1:0]        exu_result,
  output logic [XLEN-1:0]        pc,
  output logic                   rf_wen,
  output logic [4:0]             rf_waddr,
  output logic [XLEN-1:0]        rf_wdata,
  output logic                   retire,
  output logic                   halted,
  output logic [1:0]             halt_code,
  output logic                   ebreak_pulse,
  output logic [63:0]            perf_cycles,
  output logic [63:0]            perf_instret
);
  // Counter holds 0..TIMEOUT-1; the last WAIT cycle is the one where it equals CntMax.
  localparam int unsigned   CntW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  seq_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [1:0]      code_q, code_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] target, pc_plus4;

  assign target   = exu_result & ~XLEN'(1);
  assign pc_plus4 = pc_q + XLEN'(4);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    inst_d         = inst_q;
    code_d         = code_q;
    cnt_d          = cnt_q;
    imem.imem_req_valid = 1'b0;
    rf_wdata       = exu_result;
    retire         = 1'b0;
    ebreak_pulse   = 1'b0;
    unique case (state_q)
      StFetch: begin
        imem.imem_req_valid = 1'b1;
        if (imem.imem_req_ready) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        // A response arriving on the timeout cycle still wins.
        if (imem.imem_rsp_valid) begin
          if (imem.imem_rsp_err) begin
            state_d = StHalt;
            code_d  = HALT_BUS_ERR;
          end else begin
            inst_d  = imem.imem_rsp_data;
            state_d = StExec;
          end
        end else if (cnt_q == CntMax) begin
          state_d = StHalt;
          code_d  = HALT_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StExec: begin
        if (op_type == OP_EBREAK) begin
          ebreak_pulse = 1'b1;
          state_d      = StHalt;
          code_d       = HALT_EBREAK;
        end else if (op_type == OP_JUMP) begin
          if (target[1:0] != 2'b00) begin
            state_d = StHalt;
            code_d  = HALT_MISALIGN;
          end else begin
            rf_wdata = pc_plus4;
            pc_d     = target;
            retire   = 1'b1;
            state_d  = StFetch;
          end
        end else begin
          pc_d    = pc_plus4;
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StHalt: begin
      end
    endcase
    rf_wen = retire && (rd != 5'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      code_q  <= HALT_EBREAK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem.imem_req_addr = pc_q;
  assign pc        = pc_q;
  assign inst      = inst_q;
  assign rf_waddr  = rd;
  assign halted    = (state_q == StHalt);
  assign halt_code = code_q;

`ifdef YSYX_25050147_PERF_CNT_EN
  ysyx_25050147_perf_cnt u_cycles (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!halted),
    .count (perf_cycles)
  );

  ysyx_25050147_perf_cnt u_instret (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (retire),
    .count (perf_instret)
  );
`else
  assign perf_cycles  = 64'd0;
  assign perf_instret = 64'd0;
`endif
endmodule

// File: tb/tb_ysyx_25050147_mc_seq.sv
// Directed bench for the multi-cycle sequencer: vector table plus halt/reset corner sequences.
module tb_ysyx_25050147_mc_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst;
  logic [4:0]  op_type = 5'd2;
  logic [4:0]  rd = 5'd0;
  logic [31:0] exu_result = 32'd0;
  logic [31:0] pc;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        retire;
  logic        halted;
  logic [1:0]  halt_code;
  logic        ebreak_pulse;
  logic [63:0] perf_cycles;
  logic [63:0] perf_instret;

  int n_vec = 0;
  int n_bad = 0;

  ysyx_25050147_mc_seq_if #(.XLEN(32)) imem ();

  ysyx_25050147_mc_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (imem),
    .inst         (inst),
    .op_type      (op_type),
    .rd           (rd),
    .exu_result   (exu_result),
    .pc           (pc),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .retire       (retire),
    .halted       (halted),
    .halt_code    (halt_code),
    .ebreak_pulse (ebreak_pulse),
    .perf_cycles  (perf_cycles),
    .perf_instret (perf_instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    int          rdy;
    int          rsp;
    logic [4:0]  op;
    logic [4:0]  rdn;
    logic [31:0] res;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] next;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem.imem_req_ready = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_err   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fetch_accept();
    imem.imem_req_ready = 1'b1;
    @(negedge clk);
    imem.imem_req_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data, input logic err);
    imem.imem_rsp_valid = 1'b1;
    imem.imem_rsp_data  = data;
    imem.imem_rsp_err   = err;
    @(negedge clk);
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_err   = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input logic [31:0] data);
    op_type    = v.op;
    rd         = v.rdn;
    exu_result = v.res;
    if (v.rst) do_reset();
    for (int k = 0; k <= v.rdy; k++) begin
      check("req_valid", 64'(imem.imem_req_valid), 64'd1);
      check("req_addr", 64'(imem.imem_req_addr), 64'(v.addr));
      if (k == v.rdy) imem.imem_req_ready = 1'b1;
      @(negedge clk);
    end
    imem.imem_req_ready = 1'b0;
    check("wait_no_req", 64'(imem.imem_req_valid), 64'd0);
    repeat (v.rsp) @(negedge clk);
    respond(data, 1'b0);
    check("exec_inst", 64'(inst), 64'(data));
    check("exec_wen", 64'(rf_wen), 64'(v.wen));
    if (v.wen) check("exec_waddr", 64'(rf_waddr), 64'(v.rdn));
    check("exec_wdata", 64'(rf_wdata), 64'(v.wdata));
    check("exec_retire", 64'(retire), 64'd1);
    check("exec_ebreak", 64'(ebreak_pulse), 64'd0);
    @(negedge clk);
    check("next_pc", 64'(pc), 64'(v.next));
    check("retire_pulse", 64'(retire), 64'd0);
    check("not_halted", 64'(halted), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    vecs[0] = '{1'b1, 0, 0, 5'd2, 5'd5, 32'd7,         32'h8000_0000, 1'b1, 32'd7,         32'h8000_0004};
    vecs[1] = '{1'b1, 0, 0, 5'd1, 5'd1, 32'h8000_0100, 32'h8000_0000, 1'b1, 32'h8000_0004, 32'h8000_0100};
    vecs[2] = '{1'b0, 0, 0, 5'd1, 5'd0, 32'h8000_0200, 32'h8000_0100, 1'b0, 32'h8000_0104, 32'h8000_0200};
    vecs[3] = '{1'b0, 5, 4, 5'd2, 5'd10, 32'h1234_5678, 32'h8000_0200, 1'b1, 32'h1234_5678, 32'h8000_0204};
    vecs[4] = '{1'b0, 2, 1, 5'd1, 5'd3, 32'h8000_0011, 32'h8000_0204, 1'b1, 32'h8000_0208, 32'h8000_0010};
    vecs[5] = '{1'b0, 0, 2, 5'd3, 5'd0, 32'h0000_dead, 32'h8000_0010, 1'b0, 32'h0000_dead, 32'h8000_0014};
    vecs[6] = '{1'b0, 0, 0, 5'd1, 5'd2, 32'hffff_fffd, 32'h8000_0014, 1'b1, 32'h8000_0018, 32'hffff_fffc};
    vecs[7] = '{1'b0, 1, 0, 5'd2, 5'd4, 32'h0000_0001, 32'hffff_fffc, 1'b1, 32'h0000_0001, 32'h0000_0000};

    imem.imem_req_ready = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = 32'd0;
    imem.imem_rsp_err   = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_pc", 64'(pc), 64'h8000_0000);
    check("rst_inst", 64'(inst), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_code", 64'(halt_code), 64'd0);
    check("rst_wen", 64'(rf_wen), 64'd0);
    check("rst_retire", 64'(retire), 64'd0);
    check("rst_ebreak", 64'(ebreak_pulse), 64'd0);
    check("rst_cycles", perf_cycles, 64'd0);
    check("rst_instret", perf_instret, 64'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], 32'ha500_0000 | 32'(i));

    // Fetch timeout: 15 silent WAIT cycles survive, the 16th halts.
    do_reset();
    fetch_accept();
    repeat (15) @(negedge clk);
    check("to_not_yet", 64'(halted), 64'd0);
    @(negedge clk);
    check("to_halted", 64'(halted), 64'd1);
    check("to_code", 64'(halt_code), 64'd2);
    check("to_no_req", 64'(imem.imem_req_valid), 64'd0);
    check("to_pc", 64'(pc), 64'h8000_0000);

    // Bus error response
    do_reset();
    fetch_accept();
    respond(32'h1111_1111, 1'b1);
    check("err_halted", 64'(halted), 64'd1);
    check("err_code", 64'(halt_code), 64'd1);
    check("err_retire", 64'(retire), 64'd0);
    check("err_inst", 64'(inst), 64'd0);

    // Misaligned jump target
    do_reset();
    op_type = 5'd1; rd = 5'd1; exu_result = 32'h8000_0102;
    fetch_accept();
    respond(32'h2222_2222, 1'b0);
    check("mis_wen", 64'(rf_wen), 64'd0);
    check("mis_retire", 64'(retire), 64'd0);
    @(negedge clk);
    check("mis_halted", 64'(halted), 64'd1);
    check("mis_code", 64'(halt_code), 64'd3);
    check("mis_pc", 64'(pc), 64'h8000_0000);

    // ebreak, then reset out of HALT
    do_reset();
    op_type = 5'd0; rd = 5'd7; exu_result = 32'd9;
    fetch_accept();
    respond(32'h0010_0073, 1'b0);
    check("eb_pulse", 64'(ebreak_pulse), 64'd1);
    check("eb_retire", 64'(retire), 64'd0);
    check("eb_wen", 64'(rf_wen), 64'd0);
    @(negedge clk);
    check("eb_pulse_end", 64'(ebreak_pulse), 64'd0);
    check("eb_halted", 64'(halted), 64'd1);
    check("eb_code", 64'(halt_code), 64'd0);
    repeat (3) @(negedge clk);
    check("eb_no_req", 64'(imem.imem_req_valid), 64'd0);
    check("eb_inst_frozen", 64'(inst), 64'h0010_0073);
    do_reset();
    check("eb_rst_pc", 64'(pc), 64'h8000_0000);
    check("eb_rst_halted", 64'(halted), 64'd0);
    check("eb_rst_req", 64'(imem.imem_req_valid), 64'd1);

    // Reset during WAIT; the stale response lands in FETCH and is ignored.
    do_reset();
    fetch_accept();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    respond(32'h3333_3333, 1'b0);
    check("late_req", 64'(imem.imem_req_valid), 64'd1);
    check("late_inst", 64'(inst), 64'd0);
    v = '{1'b0, 0, 0, 5'd2, 5'd6, 32'd42, 32'h8000_0000, 1'b1, 32'd42, 32'h8000_0004};
    run_vec(v, 32'h4444_4444);

    // Ten back-to-back addis at 3 cycles each
    do_reset();
    for (int i = 0; i < 10; i++) begin
      v = '{1'b0, 0, 0, 5'd2, 5'd1, 32'(i), 32'h8000_0000 + 32'(4 * i), 1'b1, 32'(i),
            32'h8000_0004 + 32'(4 * i)};
      run_vec(v, 32'h0010_0093);
    end
`ifdef YSYX_25050147_PERF_CNT_EN
    check("perf_instret", perf_instret, 64'd10);
    check("perf_cycles", perf_cycles, 64'd30);
`else
    check("perf_instret", perf_instret, 64'd0);
    check("perf_cycles", perf_cycles, 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ysyx_25050147_mc_seq.md
Name: ysyx_25050147_mc_seq

Overview:
Multi-cycle fetch/execute sequencer replacing the single-cycle PC/writeback glue of the NPC top. Owns PC and instruction register, fetches through a valid/ready instruction-memory handshake tolerating variable latency, and gates register-file writeback. Halts on ebreak, bus error, fetch timeout or misaligned jump target. IDU/EXU stay combinational outside this block and see a stable `inst` for the whole EXEC cycle.

Parameters:
XLEN, 32, datapath/PC width
RESET_PC, 32'h80000000, PC value after reset
TIMEOUT, 16, max cycles in WAIT before timeout halt (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address (= pc)
imem_rsp_valid  in  1  response valid
imem_rsp_data  in  32  fetched instruction
imem_rsp_err  in  1  response carries bus error
inst  out  32  instruction register to IDU
op_type  in  5  from IDU: 0=ebreak, 1=jump (jal/jalr), other=sequential
rd  in  5  destination register from IDU
exu_result  in  XLEN  EXU result / jump target
pc  out  XLEN  current PC
rf_wen  out  1  register-file write enable
rf_waddr  out  5  write address
rf_wdata  out  XLEN  write data
retire  out  1  one-cycle pulse per retired instruction
halted  out  1  sticky halt flag
halt_code  out  2  0=ebreak, 1=bus error, 2=timeout, 3=misaligned target
ebreak_pulse  out  1  one-cycle pulse on ebreak (bench DPI hook)
perf_cycles  out  64  cycle counter (optional feature)
perf_instret  out  64  retired-instruction counter (optional feature)

Behaviour:
- Reset (async assert): state=FETCH, pc=RESET_PC, inst=0, halted=0, halt_code=0, timeout counter=0; all pulses and rf_wen 0; perf counters 0.
- FETCH: imem_req_valid=1, addr=pc. On valid&ready -> WAIT, timeout counter cleared. imem_rsp_valid ignored in FETCH.
- WAIT: counter increments each cycle. On rsp_valid: err=1 -> HALT, code 1; otherwise inst<=rsp_data, -> EXEC. If counter reaches TIMEOUT with no rsp -> HALT, code 2. Simultaneous rsp and timeout: response wins.
- EXEC (exactly one cycle):
  - op_type 0: no write, pc unchanged, ebreak_pulse=1, -> HALT, code 0. Not retired.
  - op_type 1: target=exu_result with bit0 cleared. If target[1:0]!=0: no write, pc unchanged, -> HALT, code 3. Else rf_wdata=pc+4, pc<=target, retire=1, -> FETCH.
  - Other: rf_wdata=exu_result, pc<=pc+4 (wraps modulo 2^XLEN), retire=1, -> FETCH.
  - rf_wen=1 only in a retiring EXEC cycle with rd!=0. rf_waddr=rd.
- HALT: absorbing until reset. No requests, no writes, pc and inst frozen, halted=1.
- Latency: minimum 3 cycles per instruction (FETCH accept, WAIT with rsp on the first WAIT cycle, EXEC).
- Reset mid-transaction: a late response arriving after reset lands in FETCH and is ignored. Memory must not return the stale response after a new request.
- imem_req_addr stays stable while valid&!ready.

Optional Feature:
YSYX_25050147_PERF_CNT_EN: defined -> perf_cycles increments every non-reset cycle while not halted; perf_instret increments on retire. Both saturate at all-ones. Undefined -> both outputs constant 0, no counter flops.

Decomposition:
- Package ysyx_25050147_core_pkg: state enum (FETCH/WAIT/EXEC/HALT), OP_EBREAK=0 and OP_JUMP=1 constants, HALT_* codes, RESET_PC default.
- Sub-module ysyx_25050147_perf_cnt: saturating 64-bit counter with enable, instantiated twice under the macro.

Test Plan:
- Reset, ready=1, rsp 1 cycle later with addi (op_type 2, rd=5, result=7) -> addr 0x80000000, rf_wen with waddr 5 / wdata 7, pc=0x80000004, retire after 3 cycles.
- jal at 0x80000000 (op 1, rd=1, result=0x80000100) -> wdata 0x80000004, pc=0x80000100. Same with rd=0 -> rf_wen stays 0.
- ready held low 5 cycles, then rsp after 4 WAIT cycles -> addr stable throughout, one retire. No rsp for 16 cycles -> halted=1, code 2.
- rsp_err=1 -> halted, code 1, no retire. Jump result 0x80000102 -> halted, code 3, pc unchanged.
- ebreak (op 0) -> ebreak_pulse exactly 1 cycle, halted, code 0, no further req_valid. Then rst_n asserted mid-HALT -> pc=0x80000000, fetch restarts.
- With the macro defined, 10 retired addis -> perf_instret=10 and perf_cycles equal to the counted cycles. Without the macro -> both 0.
